// File: rtl/pipeline_exec_controller_if.sv
// Debug-unit control bus for the pipeline execution controller.
// The master drives the run/step/halt controls; the slave returns enable and status.
interface pipeline_exec_controller_if #(
    parameter int unsigned NB_CYCLES = 32,
    parameter int unsigned NB_STATE  = 3
);
    logic                 i_program_loaded;
    logic                 i_start;
    logic                 i_step_mode;
    logic                 i_step;
    logic                 i_halt;
    logic                 o_enable;
    logic                 o_busy;
    logic                 o_done;
    logic [NB_CYCLES-1:0] o_cycle_count;
    logic [NB_STATE-1:0]  o_state;

    modport master (
        output i_program_loaded, i_start, i_step_mode, i_step, i_halt,
        input  o_enable, o_busy, o_done, o_cycle_count, o_state
    );

    modport slave (
        input  i_program_loaded, i_start, i_step_mode, i_step, i_halt,
        output o_enable, o_busy, o_done, o_cycle_count, o_state
    );
endinterface

// File: rtl/pipeline_exec_controller.sv
// Gates the global pipeline enable in continuous or single-step mode, drains
// in-flight instructions after HALT, and counts enabled cycles.
module pipeline_exec_controller #(
    parameter int unsigned N_DRAIN   = 4,
    parameter int unsigned NB_CYCLES = 32,
    parameter int unsigned NB_STATE  = 3
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    pipeline_exec_controller_if.slave  bus
);
    localparam int unsigned NB_DRAIN = $clog2(N_DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP_EXEC = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_enable;
    logic                 r_busy;
    logic                 r_done;
    logic [NB_CYCLES-1:0] r_cycle_count;
    logic                 r_draining;
    logic [NB_DRAIN-1:0]  r_drain_cnt;
    logic                 r_step_q;

    state_t               w_next_state;
    logic                 w_step_rise;
    logic                 w_accept;
    logic                 w_drain_last;

    assign w_step_rise  = bus.i_step & ~r_step_q;
    assign w_accept     = ((r_state == S_IDLE) || (r_state == S_DONE))
                          && bus.i_start && bus.i_program_loaded;
    assign w_drain_last = r_enable && r_draining && (r_drain_cnt == NB_DRAIN'(1));

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_next_state = bus.i_step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN:       w_next_state = S_RUN;
            S_STEP_WAIT: if (w_step_rise) w_next_state = S_STEP_EXEC;
            S_STEP_EXEC: w_next_state = S_STEP_WAIT;
            default:     w_next_state = S_IDLE;
        endcase
        // The final drained cycle ends the run regardless of mode.
        if (w_drain_last)
            w_next_state = S_DONE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_enable      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
            r_draining    <= 1'b0;
            r_drain_cnt   <= '0;
            r_step_q      <= 1'b0;
        end else begin
            r_step_q <= bus.i_step;
            r_state  <= w_next_state;
            r_enable <= (w_next_state == S_RUN) || (w_next_state == S_STEP_EXEC);
            r_busy   <= (w_next_state == S_RUN) || (w_next_state == S_STEP_WAIT)
                        || (w_next_state == S_STEP_EXEC);
            r_done   <= (w_next_state == S_DONE);

            if (w_accept) begin
                r_cycle_count <= '0;
                r_draining    <= 1'b0;
                r_drain_cnt   <= '0;
            end else if (r_enable) begin
                if (r_cycle_count != '1)
                    r_cycle_count <= r_cycle_count + 1'b1;
                if (!r_draining && bus.i_halt) begin
                    r_draining  <= 1'b1;
                    r_drain_cnt <= NB_DRAIN'(N_DRAIN);
                end else if (r_draining) begin
                    r_drain_cnt <= r_drain_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.o_enable      = r_enable;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_cycle_count = r_cycle_count;
    assign bus.o_state       = NB_STATE'(r_state);
endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller: a per-cycle vector table plus
// hand-written step-drain, start-gating, mid-drain reset and saturation sequences.
module tb_pipeline_exec_controller;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_exec_controller_if #(.NB_CYCLES(32), .NB_STATE(3)) bus1 ();
    pipeline_exec_controller_if #(.NB_CYCLES(3),  .NB_STATE(3)) bus2 ();

    pipeline_exec_controller #(.N_DRAIN(4), .NB_CYCLES(32), .NB_STATE(3)) u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus1.slave)
    );

    pipeline_exec_controller #(.N_DRAIN(1), .NB_CYCLES(3), .NB_STATE(3)) u_dut_sat (
        .i_clock (clk),
        .i_reset (rst2),
        .bus     (bus2.slave)
    );

    typedef struct {
        logic        rst, ld, st, md, stp, hlt;
        logic        en, busy, done;
        logic [2:0]  state;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[26];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic [2:0] st, input logic [31:0] cnt,
                          input logic en);
        check({tag, " state"}, 32'(bus1.o_state), 32'(st));
        check({tag, " count"}, bus1.o_cycle_count, cnt);
        check({tag, " enable"}, 32'(bus1.o_enable), 32'(en));
    endtask

    task automatic do_step(input logic h, input logic [2:0] exp_state, input logic [31:0] exp_cnt,
                           input string tag);
        bus1.i_step = 1'b1;
        tick();
        check({tag, " exec enable"}, 32'(bus1.o_enable), 32'd1);
        bus1.i_halt = h;
        bus1.i_step = 1'b0;
        tick();
        bus1.i_halt = 1'b0;
        check1(tag, exp_state, exp_cnt, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus1.i_program_loaded = 1'b0; bus1.i_start = 1'b0; bus1.i_step_mode = 1'b0;
        bus1.i_step = 1'b0;           bus1.i_halt = 1'b0;
        bus2.i_program_loaded = 1'b0; bus2.i_start = 1'b0; bus2.i_step_mode = 1'b0;
        bus2.i_step = 1'b0;           bus2.i_halt = 1'b0;

        // {rst, ld, st, md, stp, hlt,  en, busy, done, state, cnt}
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 32'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd1, 32'd0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd1, 32'd1};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd1, 32'd2};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 3'd1, 32'd3};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd1, 32'd4};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd1, 32'd5};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd1, 32'd6};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 3'd4, 32'd7};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 3'd4, 32'd7};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd2, 32'd0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd2, 32'd0};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 3'd3, 32'd0};
        for (int i = 13; i <= 20; i++)
            vecs[i] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 3'd2, 32'd1};
        vecs[21] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd2, 32'd1};
        vecs[22] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 3'd3, 32'd1};
        vecs[23] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd2, 32'd2};
        vecs[24] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 3'd3, 32'd2};
        vecs[25] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd2, 32'd3};

        for (int i = 0; i < 26; i++) begin
            rst                   = vecs[i].rst;
            bus1.i_program_loaded = vecs[i].ld;
            bus1.i_start          = vecs[i].st;
            bus1.i_step_mode      = vecs[i].md;
            bus1.i_step           = vecs[i].stp;
            bus1.i_halt           = vecs[i].hlt;
            tick();
            check($sformatf("v%0d enable", i), 32'(bus1.o_enable), 32'(vecs[i].en));
            check($sformatf("v%0d busy", i),   32'(bus1.o_busy),   32'(vecs[i].busy));
            check($sformatf("v%0d done", i),   32'(bus1.o_done),   32'(vecs[i].done));
            check($sformatf("v%0d state", i),  32'(bus1.o_state),  32'(vecs[i].state));
            check($sformatf("v%0d count", i),  bus1.o_cycle_count, vecs[i].cnt);
        end

        // Step-mode drain; halt while not enabled and halt while draining are ignored
        rst = 1'b1; tick(); rst = 1'b0;
        check1("sd reset", 3'd0, 32'd0, 1'b0);
        bus1.i_start = 1'b1; bus1.i_step_mode = 1'b1; tick();
        bus1.i_start = 1'b0; bus1.i_step_mode = 1'b0;
        check1("sd start", 3'd2, 32'd0, 1'b0);
        bus1.i_halt = 1'b1; tick(); bus1.i_halt = 1'b0;
        check1("sd idle halt", 3'd2, 32'd0, 1'b0);
        do_step(1'b0, 3'd2, 32'd1, "sd step1");
        do_step(1'b1, 3'd2, 32'd2, "sd step2");
        do_step(1'b0, 3'd2, 32'd3, "sd step3");
        do_step(1'b1, 3'd2, 32'd4, "sd step4");
        do_step(1'b0, 3'd2, 32'd5, "sd step5");
        do_step(1'b0, 3'd4, 32'd6, "sd step6");
        bus1.i_step = 1'b1; tick();
        check1("sd step after done", 3'd4, 32'd6, 1'b0);
        bus1.i_step = 1'b0; tick();
        check("sd done flag", 32'(bus1.o_done), 32'd1);

        // Start gating
        rst = 1'b1; tick(); rst = 1'b0;
        bus1.i_program_loaded = 1'b0; bus1.i_start = 1'b1; tick();
        check1("gate no program", 3'd0, 32'd0, 1'b0);
        bus1.i_program_loaded = 1'b1; tick();
        bus1.i_start = 1'b0;
        check1("gate start", 3'd1, 32'd0, 1'b1);
        repeat (3) tick();
        bus1.i_start = 1'b1; bus1.i_step_mode = 1'b1; tick();
        bus1.i_start = 1'b0; bus1.i_step_mode = 1'b0;
        check1("gate start while run", 3'd1, 32'd4, 1'b1);

        // Reset mid-drain, then a fresh run needs its own halt
        bus1.i_halt = 1'b1; tick(); bus1.i_halt = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check1("mid-drain reset", 3'd0, 32'd0, 1'b0);
        check("mid-drain reset busy", 32'(bus1.o_busy), 32'd0);
        bus1.i_start = 1'b1; tick(); bus1.i_start = 1'b0;
        check1("fresh start", 3'd1, 32'd0, 1'b1);
        repeat (8) tick();
        check1("fresh run no stale drain", 3'd1, 32'd8, 1'b1);
        bus1.i_halt = 1'b1; tick(); bus1.i_halt = 1'b0;
        repeat (3) tick();
        check1("fresh drain last", 3'd1, 32'd12, 1'b1);
        tick();
        check1("fresh done", 3'd4, 32'd13, 1'b0);
        check("fresh done flag", 32'(bus1.o_done), 32'd1);

        // 3-bit counter saturation and minimum drain length
        tick();
        check("sat reset state", 32'(bus2.o_state), 32'd0);
        rst2 = 1'b0;
        bus2.i_program_loaded = 1'b1; bus2.i_start = 1'b1; tick(); bus2.i_start = 1'b0;
        repeat (9) tick();
        check("sat count", 32'(bus2.o_cycle_count), 32'd7);
        check("sat state", 32'(bus2.o_state), 32'd1);
        bus2.i_halt = 1'b1; tick(); bus2.i_halt = 1'b0;
        check("sat halt cycle state", 32'(bus2.o_state), 32'd1);
        tick();
        check("sat drain1 done state", 32'(bus2.o_state), 32'd4);
        check("sat drain1 count", 32'(bus2.o_cycle_count), 32'd7);
        check("sat drain1 enable", 32'(bus2.o_enable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
